// File: rtl/mavg_mc.sv
// Multi-channel time-multiplexed moving-sum filter, one sample per cycle, 1-cycle latency.
// Define MAVG_MC_AVG_EN to output the window average (acc >>> LD) instead of the raw sum.
module mavg_mc #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CH    = 2,
    localparam int LD   = $clog2(DEPTH),
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1,
    localparam int YW   = W + LD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] ch,
    input  logic [W-1:0]  x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] y_ch,
    output logic          y_valid
);

    logic signed [W-1:0]  ring [CH][DEPTH];
    logic        [LD-1:0] ptr  [CH];
    logic signed [YW-1:0] acc  [CH];

    logic [31:0]          ch_ext;
    logic                 ch_ok;
    logic                 take;
    logic [CW-1:0]        ch_sel;
    logic signed [W-1:0]  old;
    logic signed [YW-1:0] x_ext;
    logic signed [YW-1:0] old_ext;
    logic signed [YW-1:0] acc_new;

    // Out-of-range channel indices are steered to channel 0 for the read path only;
    // take stays low so nothing is written.
    always_comb begin
        ch_ext  = 32'(ch);
        ch_ok   = (ch_ext < 32'(CH));
        take    = en && !clr && ch_ok;
        ch_sel  = ch_ok ? ch : '0;
        old     = ring[ch_sel][ptr[ch_sel]];
        x_ext   = {{LD{x[W-1]}}, x};
        old_ext = {{LD{old[W-1]}}, old};
        acc_new = acc[ch_sel] + x_ext - old_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    ring[c][d] <= '0;
                end
                ptr[c] <= '0;
                acc[c] <= '0;
            end
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
        end else if (clr) begin
            for (int c = 0; c < CH; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    ring[c][d] <= '0;
                end
                ptr[c] <= '0;
                acc[c] <= '0;
            end
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
        end else if (take) begin
            ring[ch_sel][ptr[ch_sel]] <= x;
            ptr[ch_sel]               <= ptr[ch_sel] + 1'b1;
            acc[ch_sel]               <= acc_new;
`ifdef MAVG_MC_AVG_EN
            y                         <= acc_new >>> LD;
`else
            y                         <= acc_new;
`endif
            y_ch                      <= ch_sel;
            y_valid                   <= 1'b1;
        end else begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mavg_mc.sv
// Bench for mavg_mc: queue-based window model checked every cycle, plus literal expectations.
module tb_mavg_mc;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CH    = 2;
    localparam int LD    = 2;
    localparam int CW    = 1;
    localparam int YW    = W + LD;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          en;
    logic [CW-1:0] ch;
    logic [W-1:0]  x;
    logic [YW-1:0] y;
    logic [CW-1:0] y_ch;
    logic          y_valid;

    mavg_mc #(.W(W), .DEPTH(DEPTH), .CH(CH)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .ch(ch), .x(x),
        .y(y), .y_ch(y_ch), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint hist [CH][$];
    longint exp_y   = 0;
    longint exp_ch  = 0;
    longint exp_v   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint ys();
        return longint'($signed(y));
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) hist[c].delete();
        exp_y  = 0;
        exp_ch = 0;
        exp_v  = 0;
    endtask

    // Drive one cycle, then advance the model to what the outputs must show after the edge.
    task automatic step(input bit e, input bit c, input int chn, input longint xv);
        longint s;
        longint xs;
        en  = e;
        clr = c;
        ch  = CW'(chn);
        x   = W'(xv);
        xs  = longint'($signed(x));
        @(posedge clk);
        #1;
        if (c) begin
            model_clear();
        end else if (e) begin
            hist[chn].push_back(xs);
            if (hist[chn].size() > DEPTH) void'(hist[chn].pop_front());
            s = 0;
            foreach (hist[chn][i]) s += hist[chn][i];
`ifdef MAVG_MC_AVG_EN
            exp_y = s >>> LD;
`else
            exp_y = s;
`endif
            exp_ch = chn;
            exp_v  = 1;
        end else begin
            exp_v = 0;
        end
    endtask

    always @(negedge clk) begin
        chk("model_y", ys(), exp_y);
        chk("model_y_ch", longint'(y_ch), exp_ch);
        chk("model_y_valid", longint'(y_valid), exp_v);
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        en  = 1'b0;
        ch  = '0;
        x   = '0;
        model_clear();
        #12;
        chk("reset_y", ys(), 0);
        chk("reset_valid", longint'(y_valid), 0);
        rst = 1'b0;

`ifndef MAVG_MC_AVG_EN
        begin
            longint e1 [5] = '{1, 3, 6, 10, 14};
            for (int i = 0; i < 5; i++) begin
                step(1, 0, 0, i + 1);
                chk("fill_ch0", ys(), e1[i]);
                chk("fill_valid", longint'(y_valid), 1);
            end
        end

        step(0, 1, 0, 0);
        begin
            longint e0 [5] = '{10, 20, 30, 40, 40};
            longint e1 [5] = '{-3, -6, -9, -12, -12};
            for (int i = 0; i < 5; i++) begin
                step(1, 0, 0, 10);
                chk("ilv_ch0", ys(), e0[i]);
                chk("ilv_ych0", longint'(y_ch), 0);
                step(1, 0, 1, -3);
                chk("ilv_ch1", ys(), e1[i]);
                chk("ilv_ych1", longint'(y_ch), 1);
            end
        end

        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 64'h7FFF_FFFF);
        chk("max_sum", ys(), 64'h1_FFFF_FFFC);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 64'h8000_0000);
        chk("min_sum", ys(), -(64'sd1 <<< 33));

        step(1, 1, 0, 9);
        chk("clr_wins_valid", longint'(y_valid), 0);
        chk("clr_wins_y", ys(), 0);
        step(1, 0, 0, 7);
        chk("after_clr", ys(), 7);
`else
        step(0, 1, 0, 0);
        begin
            longint ea [4] = '{1, 3, 6, 10};
            for (int i = 0; i < 4; i++) begin
                step(1, 0, 0, 4 * (i + 1));
                chk("avg_ch0", ys(), ea[i]);
            end
        end
        step(0, 1, 0, 0);
        step(1, 0, 0, -1);
        chk("avg_neg_floor", ys(), -1);
        step(1, 0, 1, -3);
        chk("avg_ch1_floor", ys(), -1);
`endif

        // idle cycles: y and y_ch must hold
        step(0, 0, 1, 123);
        step(0, 0, 0, 456);

        step(0, 1, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 2);
        step(1, 0, 1, 3);
        rst = 1'b1;
        model_clear();
        #2;
        chk("async_rst_y", ys(), 0);
        chk("async_rst_ych", longint'(y_ch), 0);
        chk("async_rst_valid", longint'(y_valid), 0);
        en = 1'b0;
        #10;
        rst = 1'b0;
        step(1, 0, 0, 5);
`ifndef MAVG_MC_AVG_EN
        chk("post_rst", ys(), 5);
`else
        chk("post_rst", ys(), 1);
`endif

        for (int i = 0; i < 30; i++) begin
            step((i % 5) != 4, 0, (i % 3 == 1) ? 1 : 0,
                 longint'((i * 12345 - 100000) * ((i % 2) ? -1 : 1)));
        end
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
